// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// Receive-side character buffer placed directly after the UART receiver.
// Each completed character is captured on the one-cycle recv strobe together
// with its parity and framing error flags. Characters are held in a
// first-word-fall-through FIFO until the register read path pops them.
//
// Ports:
//   clk, arst          clock and asynchronous active-high reset
//   recv               character-complete strobe from the receiver
//   recv_data          received character (valid with recv)
//   recv_parity_err    parity error of the received character
//   recv_frame_err     stop-bit error of the received character
//   rd_en              pop the head entry
//   flush              synchronous clear of the FIFO contents
//   ovr_clr            clear the sticky overrun flag
//   thresh             interrupt threshold, 0 disables the interrupt
//   rd_data            head character (0 while empty)
//   rd_parity_err      parity flag of the head entry (0 while empty)
//   rd_frame_err       frame flag of the head entry (0 while empty)
//   empty, full        FIFO occupancy flags
//   level              entry count, 0..DEPTH
//   overrun            sticky: a character was dropped because the FIFO was full
//   thresh_irq         level >= thresh with thresh != 0
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8
) (
    input  logic                       clk,
    input  logic                       arst,
    input  logic                       recv,
    input  logic [DATA_W-1:0]          recv_data,
    input  logic                       recv_parity_err,
    input  logic                       recv_frame_err,
    input  logic                       rd_en,
    input  logic                       flush,
    input  logic                       ovr_clr,
    input  logic [$clog2(DEPTH):0]     thresh,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       rd_parity_err,
    output logic                       rd_frame_err,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overrun,
    output logic                       thresh_irq
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = DATA_W + 2;

    // Storage entry layout: {frame_err, parity_err, data}
    logic [EW-1:0] mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic          overrun_r;

    logic          empty_s;
    logic          full_s;
    logic [PW-1:0] level_s;
    logic          pop_s;
    logic          push_s;
    logic          overflow_s;
    logic [EW-1:0] head_s;

    // Occupancy decode and push/pop qualification
    always_comb begin
        empty_s    = (wr_ptr_r == rd_ptr_r);
        full_s     = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
        level_s    = wr_ptr_r - rd_ptr_r;
        pop_s      = rd_en && !empty_s && !flush;
        // A same-cycle pop frees the slot, so a push at full still lands.
        push_s     = recv && (!full_s || pop_s) && !flush;
        overflow_s = recv && full_s && !pop_s && !flush;
    end

    // Pointer update; flush takes priority over push and pop
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
            end
        end
    end

    // Character storage written at the tail on an accepted push
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {EW{1'b0}};
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= {recv_frame_err, recv_parity_err, recv_data};
        end
    end

    // Sticky overrun: a new overflow wins over a coincident clear
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            overrun_r <= 1'b0;
        end else if (overflow_s) begin
            overrun_r <= 1'b1;
        end else if (ovr_clr) begin
            overrun_r <= 1'b0;
        end
    end

    // First-word-fall-through head view, forced to zero while empty
    always_comb begin
        head_s = {EW{1'b0}};
        if (!empty_s) begin
            head_s = mem_r[rd_ptr_r[AW-1:0]];
        end else begin
            head_s = {EW{1'b0}};
        end
    end

    assign rd_data       = head_s[DATA_W-1:0];
    assign rd_parity_err = head_s[DATA_W];
    assign rd_frame_err  = head_s[DATA_W+1];
    assign empty         = empty_s;
    assign full          = full_s;
    assign level         = level_s;
    assign overrun       = overrun_r;
    assign thresh_irq    = (thresh != {PW{1'b0}}) && (level_s >= thresh);

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

    localparam int DEPTH  = 16;
    localparam int DATA_W = 8;
    localparam int PW     = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              arst;
    logic              recv;
    logic [DATA_W-1:0] recv_data;
    logic              recv_parity_err;
    logic              recv_frame_err;
    logic              rd_en;
    logic              flush;
    logic              ovr_clr;
    logic [PW-1:0]     thresh;
    logic [DATA_W-1:0] rd_data;
    logic              rd_parity_err;
    logic              rd_frame_err;
    logic              empty;
    logic              full;
    logic [PW-1:0]     level;
    logic              overrun;
    logic              thresh_irq;

    uart_rx_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk             (clk),
        .arst            (arst),
        .recv            (recv),
        .recv_data       (recv_data),
        .recv_parity_err (recv_parity_err),
        .recv_frame_err  (recv_frame_err),
        .rd_en           (rd_en),
        .flush           (flush),
        .ovr_clr         (ovr_clr),
        .thresh          (thresh),
        .rd_data         (rd_data),
        .rd_parity_err   (rd_parity_err),
        .rd_frame_err    (rd_frame_err),
        .empty           (empty),
        .full            (full),
        .level           (level),
        .overrun         (overrun),
        .thresh_irq      (thresh_irq)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Scoreboard entries: {frame_err, parity_err, data}
    logic [9:0] sb_q[$];
    logic       exp_ovr_r;
    logic [9:0] last_pop_s;
    int         n_cmp;
    int         n_err;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Compare every observable output against the bench model
    task automatic check_state(input string tag);
        logic [9:0] head;
        int         lvl;
        head = (sb_q.size() > 0) ? sb_q[0] : 10'h000;
        lvl  = sb_q.size();
        check_eq({tag, ".empty"},   32'(empty),         32'(lvl == 0));
        check_eq({tag, ".full"},    32'(full),          32'(lvl == DEPTH));
        check_eq({tag, ".level"},   32'(level),         32'(lvl));
        check_eq({tag, ".overrun"}, 32'(overrun),       32'(exp_ovr_r));
        check_eq({tag, ".rd_data"}, 32'(rd_data),       32'(head[7:0]));
        check_eq({tag, ".rd_pe"},   32'(rd_parity_err), 32'(head[8]));
        check_eq({tag, ".rd_fe"},   32'(rd_frame_err),  32'(head[9]));
        check_eq({tag, ".irq"},     32'(thresh_irq),
                 32'((thresh != 0) && (lvl >= int'(thresh))));
    endtask

    // One clock of stimulus; model updated from the same inputs
    task automatic drive_cycle(input logic r, input logic [7:0] d, input logic pe,
                               input logic fe, input logic re, input logic fl,
                               input logic oc);
        logic pop;
        logic was_full;
        logic ovf;
        pop      = re && (sb_q.size() > 0) && !fl;
        was_full = (sb_q.size() == DEPTH);
        ovf      = r && was_full && !pop && !fl;
        if (pop) begin
            check_eq("pop_data", 32'({rd_frame_err, rd_parity_err, rd_data}), 32'(sb_q[0]));
            last_pop_s = sb_q.pop_front();
        end
        if (fl) begin
            sb_q.delete();
        end else if (r && (!was_full || pop)) begin
            sb_q.push_back({fe, pe, d});
        end
        if (ovf)     exp_ovr_r = 1'b1;
        else if (oc) exp_ovr_r = 1'b0;
        recv = r; recv_data = d; recv_parity_err = pe; recv_frame_err = fe;
        rd_en = re; flush = fl; ovr_clr = oc;
        @(posedge clk);
        #1;
        recv = 1'b0; recv_data = 8'h00; recv_parity_err = 1'b0; recv_frame_err = 1'b0;
        rd_en = 1'b0; flush = 1'b0; ovr_clr = 1'b0;
    endtask

    task automatic push(input logic [7:0] d);
        drive_cycle(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop_one();
        drive_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        n_cmp = 0; n_err = 0; exp_ovr_r = 1'b0; last_pop_s = 10'h000;
        arst = 1'b1; recv = 1'b0; recv_data = 8'h00; recv_parity_err = 1'b0;
        recv_frame_err = 1'b0; rd_en = 1'b0; flush = 1'b0; ovr_clr = 1'b0;
        thresh = 5'd0;
        #12;
        check_state("reset");
        arst = 1'b0;
        @(posedge clk); #1;

        // Fill and drain
        for (int i = 0; i < DEPTH; i++) push(8'(8'h11 + i));
        check_state("filled");
        for (int i = 0; i < DEPTH; i++) pop_one();
        check_state("drained");
        pop_one();  // pop while empty is ignored
        check_state("pop_empty");

        // Overflow and overrun clear
        for (int i = 0; i < DEPTH; i++) push(8'(8'h11 + i));
        push(8'hAA);
        check_state("overflow");
        drive_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_state("ovr_clr");
        drive_cycle(1'b1, 8'hAB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_state("ovr_clr_vs_set");
        drive_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_state("ovr_clr2");

        // Push and pop at full
        drive_cycle(1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_state("push_pop_full");
        for (int i = 0; i < DEPTH; i++) pop_one();
        check_eq("last_pop", 32'(last_pop_s[7:0]), 32'h55);
        check_state("drained2");

        // Error flags
        drive_cycle(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, 8'h3D, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_state("flags_head1");
        pop_one();
        check_state("flags_head2");
        pop_one();
        check_state("flags_done");

        // Threshold, overflow, then flush with a coincident character
        thresh = 5'd4;
        for (int i = 0; i < 4; i++) begin
            push(8'(8'h60 + i));
            check_state("thresh_fill");
        end
        for (int i = 4; i < DEPTH; i++) push(8'(8'h60 + i));
        thresh = 5'd17;
        #1;
        check_state("thresh_above_depth");
        thresh = 5'd4;
        push(8'hEE);
        check_state("overflow2");
        drive_cycle(1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check_state("flush");
        push(8'h01);
        check_state("after_flush");
        pop_one();

        // Asynchronous reset mid-operation
        for (int i = 0; i < 5; i++) push(8'(8'h30 + i));
        check_state("pre_reset");
        #2 arst = 1'b1;
        #1;
        sb_q.delete();
        exp_ovr_r = 1'b0;
        check_state("async_reset");
        #2 arst = 1'b0;
        push(8'h42);
        check_state("post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
